// File: rtl/sbox_cfg_pkg.sv
// Shared geometry, state encoding and row type for the programmable 5-bit S-box loader.
package sbox_cfg_pkg;
  localparam int COL_W    = 5;
  localparam int COLS     = 4;
  localparam int ROWS     = 8;
  localparam int ENTRIES  = ROWS * COLS;
  localparam int COL_BITS = $clog2(COLS);
  localparam int ROW_BITS = $clog2(ROWS);
  localparam int ADDR_W   = ROW_BITS + COL_BITS;
  localparam int CNT_W    = ADDR_W + 1;
  localparam int ROW_W    = COLS * COL_W;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, VERIFY, DONE} loader_state_e;

  typedef logic [ROW_W-1:0] row_t;
endpackage

// File: rtl/sbox_cfg_loader_if.sv
// Entry stream (valid/ready/data) from the configuration front-end into the S-box loader.
interface sbox_cfg_loader_if;
  import sbox_cfg_pkg::*;

  logic             s_valid_i;
  logic             s_ready_o;
  logic [COL_W-1:0] s_data_i;

  modport master (output s_valid_i, output s_data_i, input s_ready_o);
  modport slave  (input s_valid_i, input s_data_i, output s_ready_o);
endinterface

// File: rtl/sbox_cfg_loader.sv
// S-box write-side loader: packs 32 streamed entries into 8 row writes and muxes the S-box address.
// Optional read-back check of every entry after the load: define SBOX_CFG_VERIFY_EN.
//
// state  | meaning
// IDLE   | datapath owns the S-box address, waiting for start_i
// LOAD   | accepting entries into the row buffer
// WRITE  | one-cycle row write strobe to the S-box
// VERIFY | reading back all entries against the shadow copy
// DONE   | one-cycle completion pulse
module sbox_cfg_loader
  import sbox_cfg_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  sbox_cfg_loader_if.slave   s,
  input  logic [ADDR_W-1:0]  lookup_addr_i,
  output logic               sbox_update_o,
  output logic [ADDR_W-1:0]  sbox_addr_o,
  output row_t               sbox_wdata_o,
  input  logic [COL_W-1:0]   sbox_rdata_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  loader_state_e          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  row_t                   row_buf_q;
  row_t                   wdata_q;
  logic [COL_BITS-1:0]    col;
  logic [ROW_BITS-1:0]    wr_row;
  logic                   last_row;

  assign col      = cnt_q[COL_BITS-1:0];
  // cnt has already stepped past the row when WRITE is reached
  assign wr_row   = ROW_BITS'((cnt_q - CNT_W'(1)) >> COL_BITS);
  assign last_row = (cnt_q == CNT_W'(ENTRIES));

`ifdef SBOX_CFG_VERIFY_EN
  row_t              shadow_q [ROWS];
  logic [ADDR_W-1:0] vidx_q;
  logic              err_q;
  row_t              vrow;
  logic [COL_W-1:0]  vexp;

  assign vrow  = shadow_q[vidx_q[ADDR_W-1:COL_BITS]];
  assign vexp  = vrow[int'(vidx_q[COL_BITS-1:0])*COL_W +: COL_W];
  assign err_o = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) shadow_q[i] <= '0;
      vidx_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && start_i) begin
        vidx_q <= '0;
        err_q  <= 1'b0;
      end
      if (state_q == WRITE) shadow_q[wr_row] <= row_buf_q;
      if (state_q == VERIFY) begin
        vidx_q <= vidx_q + ADDR_W'(1);
        if (sbox_rdata_i != vexp) err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^sbox_rdata_i;
  assign err_o        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    s.s_ready_o   = 1'b0;
    sbox_update_o = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    sbox_addr_o   = cnt_q[ADDR_W-1:0];
    sbox_wdata_o  = wdata_q;
    case (state_q)
      IDLE: begin
        busy_o      = 1'b0;
        sbox_addr_o = lookup_addr_i;
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        s.s_ready_o = 1'b1;
        if (abort_i)                         state_d = IDLE;
        else if (s.s_valid_i && (&col))      state_d = WRITE;
      end
      WRITE: begin
        sbox_update_o = 1'b1;
        sbox_addr_o   = {wr_row, {COL_BITS{1'b0}}};
        sbox_wdata_o  = row_buf_q;
`ifdef SBOX_CFG_VERIFY_EN
        if (last_row) state_d = VERIFY;
`else
        if (last_row) state_d = DONE;
`endif
        else          state_d = LOAD;
      end
`ifdef SBOX_CFG_VERIFY_EN
      VERIFY: begin
        sbox_addr_o = vidx_q;
        if (&vidx_q) state_d = DONE;
      end
`endif
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      row_buf_q <= '0;
      wdata_q   <= '0;
    end else begin
      if (state_q == IDLE && start_i) begin
        cnt_q <= '0;
      end else if (state_q == LOAD && s.s_valid_i && !abort_i) begin
        row_buf_q[int'(col)*COL_W +: COL_W] <= s.s_data_i;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // keep the last written row on the port outside WRITE
      if (state_q == WRITE) wdata_q <= row_buf_q;
    end
  end

endmodule

// File: tb/tb_sbox_cfg_loader.sv
// Bench for sbox_cfg_loader with a behavioural S-box; honours SBOX_CFG_VERIFY_EN like the RTL.
module tb_sbox_cfg_loader;
  import sbox_cfg_pkg::*;

`ifdef SBOX_CFG_VERIFY_EN
  localparam int DONE_LAT = 33;
`else
  localparam int DONE_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  lookup = '0;
  logic        update;
  logic [4:0]  addr;
  row_t        wdata;
  logic [4:0]  rdata;
  logic        busy, done, err;
  bit          corrupt = 1'b0;

  sbox_cfg_loader_if bus ();

  sbox_cfg_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .abort_i       (abort),
    .s             (bus),
    .lookup_addr_i (lookup),
    .sbox_update_o (update),
    .sbox_addr_o   (addr),
    .sbox_wdata_o  (wdata),
    .sbox_rdata_i  (rdata),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  logic [4:0] ascon_def [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  // behavioural S-box: async reset to defaults, row write, combinational read
  logic [4:0] sbox_mem [32];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) sbox_mem[i] <= ascon_def[i];
    end else if (update) begin
      for (int c = 0; c < 4; c++) sbox_mem[addr[4:2]*4 + c] <= wdata[c*5 +: 5];
    end
  end
  assign rdata = (corrupt && addr == 5'd9) ? ~sbox_mem[addr] : sbox_mem[addr];

  int         total = 0, bad = 0;
  int         cyc = 0;
  int         strobe_idx = 0, hs_cnt = 0, last_hs_cyc = 0, last_strobe_cyc = 0, done_cnt = 0;
  bit         spacing_chk = 1'b0;
  row_t       first_wdata;
  logic [4:0] strobe_addr [8];
  logic [4:0] cur_data [32];
  logic [4:0] exp_mem [32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic row_t pack_row(input int k);
    row_t r;
    for (int c = 0; c < 4; c++) r[c*5 +: 5] = cur_data[4*k + c];
    return r;
  endfunction

  // monitor: inputs here are those the next rising edge will sample
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (update) begin
        check("ready_in_write", bus.s_ready_o, 0);
        check("strobe_latency", cyc - last_hs_cyc, 1);
        check("strobe_entries", hs_cnt, 4*(strobe_idx + 1));
        check("strobe_addr", addr, strobe_idx*4);
        check("strobe_wdata", wdata, pack_row(strobe_idx));
        if (spacing_chk && strobe_idx > 0) check("strobe_spacing", cyc - last_strobe_cyc, 5);
        if (strobe_idx == 0) first_wdata = wdata;
        if (strobe_idx < 8) strobe_addr[strobe_idx] = addr;
        last_strobe_cyc = cyc;
        strobe_idx++;
      end
      if (bus.s_valid_i && bus.s_ready_o && !abort) begin
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    strobe_idx = 0;
    hs_cnt = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] d, input int gap);
    int n;
    bus.s_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = d;
    n = 0;
    while (!bus.s_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_wait", bus.s_ready_o, 1);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", done, 1);
    check("done_latency", cyc - last_strobe_cyc, DONE_LAT);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  task automatic run_load(input int gapmax);
    spacing_chk = (gapmax == 0);
    start_load();
    for (int i = 0; i < 32; i++) send(cur_data[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    bus.s_valid_i = 1'b0;
    wait_done();
    check("strobe_count", strobe_idx, 8);
    for (int i = 0; i < 32; i++) exp_mem[i] = cur_data[i];
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      lookup = 5'(i);
      #1;
      check(tag, rdata, exp_mem[i]);
    end
  endtask

  task automatic read_row(input int r, output row_t row);
    for (int c = 0; c < 4; c++) begin
      lookup = 5'(r*4 + c);
      #1;
      row[c*5 +: 5] = rdata;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus.s_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) exp_mem[i] = ascon_def[i];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.s_ready_o, 0);
    check({tag, "_update"}, update, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_addr"}, addr, lookup);
  endtask

  initial begin
    row_t r;
    int   d0;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;

    // reset state
    @(negedge clk);
    lookup = 5'($urandom_range(0, 31));
    #1;
    check_reset_outputs("rst");
    do_reset();

    // full load with value = index, valid held high
    for (int i = 0; i < 32; i++) cur_data[i] = 5'(i);
    run_load(0);
    check("row0_wdata", first_wdata, 20'h18820);
    check("row0_addr", strobe_addr[0], 5'b00000);
    check("row7_addr", strobe_addr[7], 5'b11100);
    @(negedge clk);
    lookup = 5'd13;
    #1;
    check("read_13", rdata, 5'd13);
    check_mem("mem_full");
    check("err_clean", err, 0);

    // specific packing
    for (int i = 0; i < 32; i++) cur_data[i] = 5'($urandom_range(0, 31));
    cur_data[0] = 5'h04; cur_data[1] = 5'h16; cur_data[2] = 5'h0D; cur_data[3] = 5'h0A;
    run_load(0);
    check("pack_row0", first_wdata, 20'h536C4);
    check_mem("mem_pack");

    // backpressure / bubbles
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) cur_data[i] = 5'($urandom_range(0, 31));
      run_load(3);
      check_mem("mem_bubble");
    end

    // abort after 6 entries, abort coincident with a valid entry
    do_reset();
    for (int i = 0; i < 32; i++) cur_data[i] = 5'($urandom_range(0, 31));
    spacing_chk = 1'b0;
    d0 = done_cnt;
    start_load();
    for (int i = 0; i < 6; i++) send(cur_data[i], 0);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = cur_data[6];
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bus.s_valid_i = 1'b0;
    #1;
    check("abort_idle", busy, 0);
    check("abort_hs", hs_cnt, 6);
    repeat (10) @(negedge clk);
    check("abort_strobes", strobe_idx, 1);
    check("abort_no_done", done_cnt, d0);
    for (int i = 0; i < 4; i++) exp_mem[i] = cur_data[i];
    @(negedge clk);
    read_row(1, r);
    check("abort_row1_default", r, 20'h126BA);
    check_mem("mem_abort");
    for (int i = 0; i < 32; i++) cur_data[i] = 5'($urandom_range(0, 31));
    run_load(1);
    check_mem("mem_reload");

    // reset asserted mid-LOAD in row 3
    for (int i = 0; i < 32; i++) cur_data[i] = 5'($urandom_range(0, 31));
    spacing_chk = 1'b0;
    start_load();
    for (int i = 0; i < 13; i++) send(cur_data[i], 0);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    bus.s_valid_i = 1'b0;
    lookup = 5'($urandom_range(0, 31));
    #1;
    check_reset_outputs("midrst");
    read_row(0, r);
    check("midrst_row0_default", r, 20'hA7D64);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) exp_mem[i] = ascon_def[i];
    check_mem("mem_midrst");

`ifdef SBOX_CFG_VERIFY_EN
    // forced read-back mismatch at entry 9
    for (int i = 0; i < 32; i++) cur_data[i] = 5'($urandom_range(0, 31));
    corrupt = 1'b1;
    run_load(0);
    corrupt = 1'b0;
    check("verify_err_set", err, 1);
    repeat (5) @(negedge clk);
    check("verify_err_sticky", err, 1);
    for (int i = 0; i < 32; i++) cur_data[i] = 5'($urandom_range(0, 31));
    spacing_chk = 1'b1;
    start_load();
    check("verify_err_cleared", err, 0);
    for (int i = 0; i < 32; i++) send(cur_data[i], 0);
    bus.s_valid_i = 1'b0;
    wait_done();
    for (int i = 0; i < 32; i++) exp_mem[i] = cur_data[i];
    check("verify_err_clean", err, 0);
    check_mem("mem_verify");
`else
    for (int i = 0; i < 32; i++) cur_data[i] = 5'($urandom_range(0, 31));
    corrupt = 1'b1;
    run_load(0);
    corrupt = 1'b0;
    check("noverify_err_zero", err, 0);
    check_mem("mem_noverify");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sbox_cfg_loader.md
Name: sbox_cfg_loader

Overview:
Write-side controller for the programmable 5-bit ASCON S-box (8 rows × 4 columns × 5 bits).
- Accepts a stream of 32 S-box entries over a valid/ready handshake.
- Packs every 4 entries into one 20-bit row and issues one row-write per row on the S-box update port.
- Muxes the S-box address between loader traffic and the datapath's lookup address.
- Sits between the configuration front-end (CSR/DMA) and the S-box instance inside the ASCON permutation core.

Parameters:
- COL_W, 5, bits per S-box entry
- COLS, 4, entries per row (power of 2)
- ROWS, 8, rows (power of 2); ENTRIES = ROWS*COLS, ADDR_W = $clog2(ROWS)+$clog2(COLS) = 5

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse: begin a full 32-entry load; honoured only in IDLE
- abort_i  in  1  abandon the load; honoured in LOAD only
- s_valid_i  in  1  entry valid
- s_ready_o  out  1  entry accepted when s_valid_i & s_ready_o
- s_data_i  in  COL_W  entry value, ascending index order 0..31
- lookup_addr_i  in  ADDR_W  datapath S-box address, passed through when not busy
- sbox_update_o  out  1  row write strobe to S-box
- sbox_addr_o  out  ADDR_W  S-box address ([4:2] row, [1:0] col)
- sbox_wdata_o  out  COLS*COL_W  row payload
- sbox_rdata_i  in  COL_W  S-box combinational read data (used by the optional feature only)
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse on completion
- err_o  out  1  sticky verify mismatch; cleared on start

Behaviour:
- Reset values: FSM = IDLE; all counters and the row buffer = 0; s_ready_o = 0, sbox_update_o = 0, sbox_wdata_o = 0, busy_o = 0, done_o = 0, err_o = 0.
- sbox_addr_o during reset equals lookup_addr_i, because the mux is combinational and IDLE is selected.
- The S-box resets concurrently to its default contents; the loader does not rewrite them.

FSM states: IDLE, LOAD, WRITE, VERIFY (only with the optional feature), DONE.
- IDLE
  - s_ready_o = 0; sbox_addr_o = lookup_addr_i.
  - start_i → LOAD; clear entry counter and err_o.
- LOAD
  - s_ready_o = 1.
  - On handshake, s_data_i is stored in row_buf[col*COL_W +: COL_W] (col = cnt[1:0]) and cnt increments.
  - A handshake with col == COLS-1 → WRITE.
  - abort_i with no handshake → IDLE. Rows already written stay written; no done_o.
  - abort_i in the same cycle as a handshake: abort wins and the entry is dropped.
- WRITE (exactly one cycle)
  - s_ready_o = 0; sbox_update_o = 1; sbox_addr_o = {row, 2'b00}; sbox_wdata_o = row_buf.
  - Latency: the strobe appears the cycle after the 4th handshake of a row.
  - row == ROWS-1 → VERIFY if enabled, else DONE. Otherwise → LOAD.
- DONE
  - done_o = 1 for one cycle → IDLE.

Width and addressing rules:
- row = cnt[ADDR_W-1:2] and col = cnt[1:0].
- cnt is ADDR_W+1 bits, so 32 does not wrap to 0 before DONE.
- sbox_wdata_o holds its last value outside WRITE, but is only meaningful while the strobe is high.

Edge cases:
- start_i outside IDLE: ignored.
- abort_i outside LOAD: ignored.
- Reset mid-operation: immediate return to IDLE. A partial load is lost and the S-box holds its defaults.
- In LOAD/WRITE, sbox_addr_o is driven by the loader. The datapath must not perform lookups while busy_o is high.

Optional Feature:
Macro: SBOX_CFG_VERIFY_EN
- Defined:
  - A shadow array ROWS × (COLS*COL_W) captures each row at WRITE.
  - VERIFY state: a 5-bit vidx steps 0..31, one entry per cycle, with sbox_addr_o = vidx.
  - sbox_rdata_i is compared to shadow[vidx[4:2]][vidx[1:0]*COL_W +: COL_W]; any mismatch sets err_o.
  - After vidx = 31 → DONE. The load takes 32 extra cycles.
- Not defined: no shadow array and no VERIFY state; err_o tied to 0; sbox_rdata_i unused.

Decomposition:
- Package sbox_cfg_pkg holds:
  - the shared S-box geometry constants (COL_W, COLS, ROWS, ENTRIES, ADDR_W)
  - the typedef enum logic [2:0] loader_state_e {IDLE, LOAD, WRITE, VERIFY, DONE}
  - the row-payload typedef
- No sub-module: the FSM, packer and address mux form one block.
- The bench instantiates sbox_cfg_loader together with the existing S-box.

Test Plan:
- Full load: start, stream entries value = index 0..31 with s_valid held high.
  - Expect 8 update strobes, each 5 cycles apart.
  - Row 0 wdata = 20'h18820 at addr 5'b00000; row 7 addr = 5'b11100.
  - done_o pulse; S-box read of addr 5'd13 returns 5'd13.
- Specific packing: entries 0..3 = 0x04, 0x16, 0x0D, 0x0A → row 0 wdata = 20'h536C4.
- Backpressure/bubbles: random s_valid gaps. Expect no strobe until the 4th accepted entry of a row, identical final contents, and s_ready_o = 0 in WRITE cycles.
- Abort after 6 entries → IDLE with no done_o. Row 0 is written, rows 1..7 keep their reset defaults (row 1 = 20'h126BA). A subsequent start reloads cleanly.
- Reset asserted mid-LOAD (row 3) → every output returns to its reset value within the same cycle. The S-box shows defaults (row 0 = 20'hA7D64).
- With SBOX_CFG_VERIFY_EN: normal load gives err_o = 0, and done_o arrives 32 cycles later than without the macro. The bench forces sbox_rdata_i to the wrong value at vidx = 9, so err_o = 1, stays set, and clears on the next start_i.
